// File: rtl/node_pkg.sv
// ============================================================================
// node_pkg : shared packet layout and FSM state types for the node port
// Revision : 1.0
// ============================================================================
`default_nettype none

package node_pkg;

    typedef struct packed {
        logic [7:0]  type_seq;
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [15:0] data;
    } pkt_t;

    localparam int BYTES_PER_PKT = 4;
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PKT - 1);

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_SEND = 2'd1,
        T_GAP  = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_CAP  = 2'd1,
        R_HOLD = 2'd2
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/node_port_pkt_deserializer.sv
// ============================================================================
// pkt_deserializer : byte-serial inbound capture into a held 32-bit packet
// Revision : 1.0
// ============================================================================
`default_nettype none

module pkt_deserializer
    import node_pkg::*;
#(
    parameter logic [3:0] NODEID = 4'd0
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        put_inbound,
    input  logic [7:0]  payload_inbound,
    input  logic        rx_ready,
    output logic        free_inbound,
    output logic [31:0] rx_pkt,
    output logic        rx_valid,
    output logic        rx_misroute,
    output logic        rx_err
);

    rx_state_t   state_q;
    logic [23:0] shift_q;
    logic [1:0]  cnt_q;
    logic        free_q;
    pkt_t        pkt_q;
    logic        valid_q;
    logic        misroute_q;
    logic        err_q;
    pkt_t        word_d;

    // Only the three earlier bytes are stored; the last one completes the word directly.
    assign word_d = pkt_t'({shift_q, payload_inbound});

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q    <= R_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            free_q     <= 1'b0;
            pkt_q      <= '0;
            valid_q    <= 1'b0;
            misroute_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                R_IDLE: begin
                    if (free_q && put_inbound) begin
                        shift_q <= {16'h0000, payload_inbound};
                        cnt_q   <= 2'd1;
                        free_q  <= 1'b0;
                        state_q <= R_CAP;
                    end else begin
                        free_q <= 1'b1;
                    end
                end
                R_CAP: begin
                    if (put_inbound) begin
                        shift_q <= word_d[23:0];
                        cnt_q   <= cnt_q + 2'd1;
                        if (cnt_q == LAST_BYTE) begin
                            pkt_q      <= word_d;
                            valid_q    <= 1'b1;
                            misroute_q <= (word_d.dest != NODEID);
                            state_q    <= R_HOLD;
                        end
                    end else begin
                        err_q   <= 1'b1;
                        free_q  <= 1'b1;
                        state_q <= R_IDLE;
                    end
                end
                R_HOLD: begin
                    if (valid_q && rx_ready) begin
                        valid_q    <= 1'b0;
                        misroute_q <= 1'b0;
                        free_q     <= 1'b1;
                        state_q    <= R_IDLE;
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    assign free_inbound = free_q;
    assign rx_pkt       = pkt_q;
    assign rx_valid     = valid_q;
    assign rx_misroute  = misroute_q;
    assign rx_err       = err_q;

endmodule

`default_nettype wire

// File: rtl/node_port.sv
// ============================================================================
// node_port : node-side router link endpoint, TX FIFO + serializer, RX path
// Revision : 1.0
// ============================================================================
`default_nettype none

module node_port
    import node_pkg::*;
#(
    parameter logic [3:0] NODEID  = 4'd0,
    parameter int         TXDEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] tx_pkt,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        free_outbound,
    output logic        put_outbound,
    output logic [7:0]  payload_outbound,
    output logic        free_inbound,
    input  logic        put_inbound,
    input  logic [7:0]  payload_inbound,
    output logic [31:0] rx_pkt,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_misroute,
    output logic        rx_err
);

    localparam int            AW       = (TXDEPTH > 1) ? $clog2(TXDEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(TXDEPTH);

    pkt_t          fifo_q [TXDEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          tx_ready_q;
    tx_state_t     tx_state_q;
    logic [23:0]   tx_shift_q;
    logic [1:0]    tx_cnt_q;
    logic          put_q;
    logic [7:0]    payload_q;
    pkt_t          stamp_d;
    pkt_t          head_d;
    logic          push_en;
    logic          pop_en;

    always_comb begin
        stamp_d     = pkt_t'(tx_pkt);
        stamp_d.src = NODEID;
    end

    assign head_d  = fifo_q[rd_ptr_q];
    assign push_en = tx_valid && tx_ready_q;
    assign pop_en  = (tx_state_q == T_IDLE) && (count_q != '0) && free_outbound;
    assign count_d = count_q + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};

    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_q[wr_ptr_q] <= stamp_d;
        end
    end

    // Byte 0 leaves with the pop; the remaining three are shifted out of tx_shift_q.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_ready_q <= 1'b0;
            tx_state_q <= T_IDLE;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            put_q      <= 1'b0;
            payload_q  <= '0;
        end else begin
            count_q    <= count_d;
            tx_ready_q <= (count_d != FULL_CNT);
            if (push_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case (tx_state_q)
                T_IDLE: begin
                    put_q <= 1'b0;
                    if (pop_en) begin
                        payload_q  <= head_d.type_seq;
                        tx_shift_q <= head_d[23:0];
                        tx_cnt_q   <= 2'd1;
                        put_q      <= 1'b1;
                        tx_state_q <= T_SEND;
                    end
                end
                T_SEND: begin
                    payload_q  <= tx_shift_q[23:16];
                    tx_shift_q <= {tx_shift_q[15:0], 8'h00};
                    tx_cnt_q   <= tx_cnt_q + 2'd1;
                    if (tx_cnt_q == LAST_BYTE) tx_state_q <= T_GAP;
                end
                T_GAP: begin
                    put_q      <= 1'b0;
                    tx_state_q <= T_IDLE;
                end
                default: tx_state_q <= T_IDLE;
            endcase
        end
    end

    assign tx_ready         = tx_ready_q;
    assign put_outbound     = put_q;
    assign payload_outbound = payload_q;

    pkt_deserializer #(
        .NODEID (NODEID)
    ) u_rx (
        .clk             (clk),
        .rst_b           (rst_b),
        .put_inbound     (put_inbound),
        .payload_inbound (payload_inbound),
        .rx_ready        (rx_ready),
        .free_inbound    (free_inbound),
        .rx_pkt          (rx_pkt),
        .rx_valid        (rx_valid),
        .rx_misroute     (rx_misroute),
        .rx_err          (rx_err)
    );

endmodule

`default_nettype wire

// File: tb/tb_node_port.sv
// ============================================================================
// tb_node_port : scenario bench for node_port against a packet-level model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_node_port;

    localparam logic [3:0] NID = 4'd5;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] tx_pkt = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        free_outbound = 1'b0;
    logic        put_outbound;
    logic [7:0]  payload_outbound;
    logic        free_inbound;
    logic        put_inbound = 1'b0;
    logic [7:0]  payload_inbound = '0;
    logic [31:0] rx_pkt;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        rx_misroute;
    logic        rx_err;

    int n_cmp = 0;
    int n_bad = 0;

    node_port #(.NODEID(NID), .TXDEPTH(2)) dut (
        .clk(clk), .rst_b(rst_b),
        .tx_pkt(tx_pkt), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .free_outbound(free_outbound), .put_outbound(put_outbound),
        .payload_outbound(payload_outbound),
        .free_inbound(free_inbound), .put_inbound(put_inbound),
        .payload_inbound(payload_inbound),
        .rx_pkt(rx_pkt), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_misroute(rx_misroute), .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Wire-side observation of every outbound byte and the cycle it appeared in
    logic [7:0]  got_b[$];
    int unsigned got_c[$];
    logic [31:0] exp_tx[$];

    always @(negedge clk) begin
        if (put_outbound) begin
            got_b.push_back(payload_outbound);
            got_c.push_back(cyc);
        end
    end

    function automatic logic [31:0] stamp(input logic [31:0] p);
        return {p[31:24], NID, p[19:0]};
    endfunction

    function automatic logic [7:0] exp_byte(input int k);
        logic [31:0] p;
        p = exp_tx[k / 4];
        return p[31 - 8 * (k % 4) -: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tx();
        got_b.delete();
        got_c.delete();
        exp_tx.delete();
    endtask

    task automatic push_tx(input logic [31:0] p, input int maxwait, output bit ok);
        tx_pkt   = p;
        tx_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < maxwait && !ok; i++) begin
            if (tx_ready) ok = 1'b1;
            step();
        end
        tx_valid = 1'b0;
        if (ok) exp_tx.push_back(stamp(p));
    endtask

    task automatic wait_tx(input int n, input int maxcyc, output bit ok);
        for (int i = 0; i < maxcyc && got_b.size() < n; i++) step();
        ok = (got_b.size() >= n);
    endtask

    task automatic send_rx(input logic [31:0] w, input int nbytes, output bit ok);
        for (int i = 0; i < 20 && !free_inbound; i++) step();
        ok = free_inbound;
        if (ok) begin
            for (int k = 0; k < nbytes; k++) begin
                put_inbound     = 1'b1;
                payload_inbound = w[31 - 8 * k -: 8];
                step();
            end
        end
        put_inbound     = 1'b0;
        payload_inbound = 8'($urandom);
    endtask

    task automatic test_reset();
        logic [31:0] obs [8];
        string       nm  [8];
        rst_b = 1'b0;
        step();
        step();
        nm  = '{"put_outbound", "payload_outbound", "free_inbound", "rx_valid",
                "rx_pkt", "rx_misroute", "rx_err", "tx_ready"};
        obs[0] = 32'(put_outbound);  obs[1] = 32'(payload_outbound);
        obs[2] = 32'(free_inbound);  obs[3] = 32'(rx_valid);
        obs[4] = rx_pkt;             obs[5] = 32'(rx_misroute);
        obs[6] = 32'(rx_err);        obs[7] = 32'(tx_ready);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs[i] !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_%s got %h want 0", nm[i], obs[i]);
            end
        end
        rst_b = 1'b1;
        step();
        n_cmp++;
        if ({tx_ready, free_inbound} !== 2'b11) begin
            n_bad++;
            $display("FAIL post_reset_ready got tx_ready=%b free_inbound=%b want 1/1", tx_ready, free_inbound);
        end
    endtask

    task automatic test_single_tx();
        bit ok;
        clear_tx();
        free_outbound = 1'b1;
        push_tx(32'hA1F3_1234, 5, ok);
        wait_tx(4, 20, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL single_tx_timeout got %0d bytes want 4", got_b.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (got_b[k] !== exp_byte(k)) begin
                    n_bad++;
                    $display("FAIL single_tx_byte%0d got %h want %h", k, got_b[k], exp_byte(k));
                end
            end
            n_cmp++;
            if (got_c[3] - got_c[0] !== 3) begin
                n_bad++;
                $display("FAIL single_tx_contig got span %0d want 3", got_c[3] - got_c[0]);
            end
            n_cmp++;
            if ({put_outbound, payload_outbound} !== {1'b0, 8'h34}) begin
                n_bad++;
                $display("FAIL single_tx_gap got put=%b byte=%h want put=0 byte=34", put_outbound, payload_outbound);
            end
        end
        repeat (3) step();
    endtask

    task automatic test_tx_backpressure();
        bit ok1, ok2, ok;
        logic [31:0] p3;
        clear_tx();
        free_outbound = 1'b0;
        push_tx($urandom, 5, ok1);
        push_tx($urandom, 5, ok2);
        n_cmp++;
        if ({ok1, ok2, tx_ready} !== 3'b110) begin
            n_bad++;
            $display("FAIL bp_full got acc=%b%b tx_ready=%b want 11/0", ok1, ok2, tx_ready);
        end
        p3 = $urandom;
        tx_pkt = p3;
        tx_valid = 1'b1;
        repeat (4) step();
        n_cmp++;
        if (tx_ready !== 1'b0 || got_b.size() != 0) begin
            n_bad++;
            $display("FAIL bp_hold got tx_ready=%b bytes=%0d want 0/0", tx_ready, got_b.size());
        end
        free_outbound = 1'b1;
        step();
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_reassert got tx_ready=%b want 1", tx_ready);
        end
        step();
        tx_valid = 1'b0;
        exp_tx.push_back(stamp(p3));
        wait_tx(12, 40, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL bp_timeout got %0d bytes want 12", got_b.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                n_cmp++;
                if (got_b[k] !== exp_byte(k)) begin
                    n_bad++;
                    $display("FAIL bp_byte%0d got %h want %h", k, got_b[k], exp_byte(k));
                end
            end
            n_cmp++;
            if (got_c[4] - got_c[0] !== 5 || got_c[8] - got_c[4] !== 5) begin
                n_bad++;
                $display("FAIL bp_period got %0d,%0d want 5,5", got_c[4] - got_c[0], got_c[8] - got_c[4]);
            end
        end
        repeat (3) step();
    endtask

    task automatic test_rx_normal();
        bit ok, stable;
        rx_ready = 1'b0;
        send_rx(32'h0735_BEEF, 4, ok);
        n_cmp++;
        if (!ok || rx_valid !== 1'b1 || rx_pkt !== 32'h0735_BEEF || rx_misroute !== 1'b0) begin
            n_bad++;
            $display("FAIL rx_normal got v=%b pkt=%h mis=%b want 1/0735beef/0", rx_valid, rx_pkt, rx_misroute);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (free_inbound !== 1'b0 || rx_valid !== 1'b1 || rx_pkt !== 32'h0735_BEEF) stable = 1'b0;
        end
        n_cmp++;
        if (!stable) begin
            n_bad++;
            $display("FAIL rx_hold got free=%b v=%b pkt=%h want 0/1/0735beef", free_inbound, rx_valid, rx_pkt);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        n_cmp++;
        if ({rx_valid, free_inbound} !== 2'b01) begin
            n_bad++;
            $display("FAIL rx_consume got v=%b free=%b want 0/1", rx_valid, free_inbound);
        end
    endtask

    task automatic test_rx_misroute_trunc();
        bit ok;
        logic [31:0] w;
        w = $urandom;
        w[19:16] = 4'd3;
        send_rx(w, 4, ok);
        n_cmp++;
        if (!ok || rx_valid !== 1'b1 || rx_pkt !== w || rx_misroute !== (w[19:16] != NID)) begin
            n_bad++;
            $display("FAIL rx_misroute got v=%b pkt=%h mis=%b want 1/%h/1", rx_valid, rx_pkt, rx_misroute, w);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        send_rx($urandom, 2, ok);
        step();
        n_cmp++;
        if (!ok || {rx_err, free_inbound, rx_valid} !== 3'b110) begin
            n_bad++;
            $display("FAIL rx_trunc got err=%b free=%b v=%b want 1/1/0", rx_err, free_inbound, rx_valid);
        end
        step();
        n_cmp++;
        if ({rx_err, rx_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL rx_err_pulse got err=%b v=%b want 0/0", rx_err, rx_valid);
        end
    endtask

    task automatic test_concurrent();
        bit ok_t, ok_r, ok;
        logic [31:0] w;
        clear_tx();
        free_outbound = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) push_tx($urandom, 20, ok_t);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    w = $urandom;
                    if ($urandom_range(0, 1) == 1) w[19:16] = NID;
                    send_rx(w, 4, ok_r);
                    n_cmp++;
                    if (!ok_r || rx_valid !== 1'b1 || rx_pkt !== w || rx_misroute !== (w[19:16] != NID)) begin
                        n_bad++;
                        $display("FAIL conc_rx%0d got v=%b pkt=%h mis=%b want pkt %h", i, rx_valid, rx_pkt, rx_misroute, w);
                    end
                    repeat ($urandom_range(0, 3)) step();
                    rx_ready = 1'b1;
                    step();
                    rx_ready = 1'b0;
                end
            end
        join
        wait_tx(4 * exp_tx.size(), 60, ok);
        n_cmp++;
        if (!ok || exp_tx.size() != 4) begin
            n_bad++;
            $display("FAIL conc_tx_timeout got %0d bytes/%0d pkts want 16/4", got_b.size(), exp_tx.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                n_cmp++;
                if (got_b[k] !== exp_byte(k)) begin
                    n_bad++;
                    $display("FAIL conc_tx_byte%0d got %h want %h", k, got_b[k], exp_byte(k));
                end
            end
        end
        repeat (3) step();
    endtask

    task automatic test_reset_mid_tx();
        bit ok;
        clear_tx();
        free_outbound = 1'b0;
        push_tx($urandom, 5, ok);
        push_tx($urandom, 5, ok);
        free_outbound = 1'b1;
        for (int i = 0; i < 10 && !put_outbound; i++) step();
        step();
        step();
        rst_b = 1'b0;
        step();
        n_cmp++;
        if ({put_outbound, tx_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL rst_mid_tx got put=%b tx_ready=%b want 0/0", put_outbound, tx_ready);
        end
        rst_b = 1'b1;
        clear_tx();
        repeat (8) step();
        n_cmp++;
        if (got_b.size() != 0 || tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_fifo_empty got bytes=%0d tx_ready=%b want 0/1", got_b.size(), tx_ready);
        end
        push_tx($urandom, 5, ok);
        wait_tx(4, 20, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rst_resume_timeout got %0d bytes want 4", got_b.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (got_b[k] !== exp_byte(k)) begin
                    n_bad++;
                    $display("FAIL rst_resume_byte%0d got %h want %h", k, got_b[k], exp_byte(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_tx_backpressure();
        test_rx_normal();
        test_rx_misroute_trunc();
        test_concurrent();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
